// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants and state encodings for the PS/2 keyboard decoder.
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] ASC_UP    = 8'h80;
  localparam logic [7:0] ASC_DOWN  = 8'h81;
  localparam logic [7:0] ASC_LEFT  = 8'h82;
  localparam logic [7:0] ASC_RIGHT = 8'h83;

  typedef enum logic [1:0] {
    FR_IDLE  = 2'd0,
    FR_RECV  = 2'd1,
    FR_CHECK = 2'd2
  } frame_state_t;

  typedef enum logic [1:0] {
    PR_NORMAL  = 2'd0,
    PR_GOT_E0  = 2'd1,
    PR_GOT_F0  = 2'd2,
    PR_GOT_E0F0 = 2'd3
  } proto_state_t;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_ascii_map.sv
// Combinational scan-code (set 2, US layout) to ASCII lookup.
// Extended arrow keys are mapped only when PS2_EXT_KEYS_EN is defined.
module ps2_ascii_map
  import ps2_key_decoder_pkg::*;
(
  input  logic [8:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] lo_s;
  logic [7:0] hi_s;
  logic       letter_s;

  // Base (unshifted) and shifted characters for each scan code
  always_comb begin
    lo_s = 8'h00;
    hi_s = 8'h00;
    if (!code[8]) begin
      case (code[7:0])
        8'h1C: lo_s = 8'h61;  8'h32: lo_s = 8'h62;  8'h21: lo_s = 8'h63;  8'h23: lo_s = 8'h64;
        8'h24: lo_s = 8'h65;  8'h2B: lo_s = 8'h66;  8'h34: lo_s = 8'h67;  8'h33: lo_s = 8'h68;
        8'h43: lo_s = 8'h69;  8'h3B: lo_s = 8'h6A;  8'h42: lo_s = 8'h6B;  8'h4B: lo_s = 8'h6C;
        8'h3A: lo_s = 8'h6D;  8'h31: lo_s = 8'h6E;  8'h44: lo_s = 8'h6F;  8'h4D: lo_s = 8'h70;
        8'h15: lo_s = 8'h71;  8'h2D: lo_s = 8'h72;  8'h1B: lo_s = 8'h73;  8'h2C: lo_s = 8'h74;
        8'h3C: lo_s = 8'h75;  8'h2A: lo_s = 8'h76;  8'h1D: lo_s = 8'h77;  8'h22: lo_s = 8'h78;
        8'h35: lo_s = 8'h79;  8'h1A: lo_s = 8'h7A;
        8'h16: begin lo_s = 8'h31; hi_s = 8'h21; end
        8'h1E: begin lo_s = 8'h32; hi_s = 8'h40; end
        8'h26: begin lo_s = 8'h33; hi_s = 8'h23; end
        8'h25: begin lo_s = 8'h34; hi_s = 8'h24; end
        8'h2E: begin lo_s = 8'h35; hi_s = 8'h25; end
        8'h36: begin lo_s = 8'h36; hi_s = 8'h5E; end
        8'h3D: begin lo_s = 8'h37; hi_s = 8'h26; end
        8'h3E: begin lo_s = 8'h38; hi_s = 8'h2A; end
        8'h46: begin lo_s = 8'h39; hi_s = 8'h28; end
        8'h45: begin lo_s = 8'h30; hi_s = 8'h29; end
        8'h0E: begin lo_s = 8'h60; hi_s = 8'h7E; end
        8'h4E: begin lo_s = 8'h2D; hi_s = 8'h5F; end
        8'h55: begin lo_s = 8'h3D; hi_s = 8'h2B; end
        8'h54: begin lo_s = 8'h5B; hi_s = 8'h7B; end
        8'h5B: begin lo_s = 8'h5D; hi_s = 8'h7D; end
        8'h5D: begin lo_s = 8'h5C; hi_s = 8'h7C; end
        8'h4C: begin lo_s = 8'h3B; hi_s = 8'h3A; end
        8'h52: begin lo_s = 8'h27; hi_s = 8'h22; end
        8'h41: begin lo_s = 8'h2C; hi_s = 8'h3C; end
        8'h49: begin lo_s = 8'h2E; hi_s = 8'h3E; end
        8'h4A: begin lo_s = 8'h2F; hi_s = 8'h3F; end
        8'h29: begin lo_s = 8'h20; hi_s = 8'h20; end
        8'h5A: begin lo_s = 8'h0D; hi_s = 8'h0D; end
        8'h66: begin lo_s = 8'h08; hi_s = 8'h08; end
        8'h0D: begin lo_s = 8'h09; hi_s = 8'h09; end
        8'h76: begin lo_s = 8'h1B; hi_s = 8'h1B; end
        default: begin lo_s = 8'h00; hi_s = 8'h00; end
      endcase
    end else begin
`ifdef PS2_EXT_KEYS_EN
      case (code[7:0])
        8'h75: begin lo_s = ASC_UP;    hi_s = ASC_UP;    end
        8'h72: begin lo_s = ASC_DOWN;  hi_s = ASC_DOWN;  end
        8'h6B: begin lo_s = ASC_LEFT;  hi_s = ASC_LEFT;  end
        8'h74: begin lo_s = ASC_RIGHT; hi_s = ASC_RIGHT; end
        default: begin lo_s = 8'h00; hi_s = 8'h00; end
      endcase
`else
      lo_s = 8'h00;
      hi_s = 8'h00;
`endif
    end
  end

  assign letter_s = (lo_s >= 8'h61) && (lo_s <= 8'h7A);

  // Letters follow shift XOR caps; everything else follows shift only
  always_comb begin
    if (letter_s) begin
      ascii = (shift ^ caps) ? (lo_s - 8'h20) : lo_s;
    end else begin
      ascii = shift ? hi_s : lo_s;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frame FSM, make/break protocol FSM, Shift/Caps tracking and ASCII output.
// Define PS2_EXT_KEYS_EN to map the E0-prefixed arrow keys; otherwise E0 sequences are ignored.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
)
(
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_key,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic       shift_on,
  output logic       caps_on,
  output logic       frame_err
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic fall_s;

  // Two-flop synchronisers plus one extra sample of the clock for edge detection
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_prev_q <= 1'b0;
      dat_s1_q   <= 1'b0;
      dat_s2_q   <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall_s = clk_prev_q & ~clk_s2_q;

  frame_state_t  fr_state_q, fr_state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    sh_q, sh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit_s, frame_good_s, byte_stb_s;
  logic [7:0]    byte_s;

  assign tmo_hit_s    = (tmo_q == TMO_LAST) && !fall_s;
  assign frame_good_s = odd_parity_ok(sh_q[8:0]) && sh_q[9];
  assign byte_stb_s   = (fr_state_q == FR_CHECK) && frame_good_s;
  assign byte_s       = sh_q[7:0];

  // Frame FSM state and shift datapath registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fr_state_q <= FR_IDLE;
      bit_cnt_q  <= 4'd0;
      sh_q       <= 10'd0;
      tmo_q      <= '0;
    end else begin
      fr_state_q <= fr_state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      tmo_q      <= tmo_d;
    end
  end

  // Frame FSM next state
  always_comb begin
    fr_state_d = fr_state_q;
    case (fr_state_q)
      FR_IDLE: begin
        if (fall_s && !dat_s2_q) fr_state_d = FR_RECV;
        else                     fr_state_d = FR_IDLE;
      end
      FR_RECV: begin
        if (fall_s && (bit_cnt_q == 4'd9)) fr_state_d = FR_CHECK;
        else if (tmo_hit_s)                fr_state_d = FR_IDLE;
        else                               fr_state_d = FR_RECV;
      end
      FR_CHECK: fr_state_d = FR_IDLE;
      default:  fr_state_d = FR_IDLE;
    endcase
  end

  // Frame datapath: bits arrive LSB first, so they shift in from the top
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    tmo_d     = tmo_q;
    case (fr_state_q)
      FR_IDLE: begin
        bit_cnt_d = 4'd0;
        tmo_d     = '0;
      end
      FR_RECV: begin
        if (fall_s) begin
          sh_d      = {dat_s2_q, sh_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        bit_cnt_d = bit_cnt_q;
      end
    endcase
  end

  proto_state_t pr_state_q, pr_state_d;
  logic [8:0]   held_q, held_d;
  logic         lshift_q, lshift_d, rshift_q, rshift_d;
  logic         shift_on_q, shift_on_d, caps_q, caps_d;
  logic         key_valid_q, key_valid_d, frame_err_q, frame_err_d;
  logic [7:0]   scan_code_q, scan_code_d, ascii_q, ascii_d;
  logic         ext_s, brk_s, data_byte_s;
  logic [8:0]   code_s;
  logic [7:0]   cand_ascii_s, held_ascii_s;

  assign ext_s       = (pr_state_q == PR_GOT_E0) || (pr_state_q == PR_GOT_E0F0);
  assign brk_s       = (pr_state_q == PR_GOT_F0) || (pr_state_q == PR_GOT_E0F0);
  assign data_byte_s = byte_stb_s && (byte_s != SC_E0) && (byte_s != SC_F0);
  assign code_s      = {ext_s, byte_s};

  ps2_ascii_map u_cand_map (.code(code_s), .shift(shift_on_q), .caps(caps_q), .ascii(cand_ascii_s));
  ps2_ascii_map u_held_map (.code(held_q), .shift(shift_on_q), .caps(caps_q), .ascii(held_ascii_s));

  // Protocol FSM state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) pr_state_q <= PR_NORMAL;
    else       pr_state_q <= pr_state_d;
  end

  // Protocol FSM next state
  always_comb begin
    pr_state_d = pr_state_q;
    if (!byte_stb_s) begin
      pr_state_d = pr_state_q;
    end else if (byte_s == SC_E0) begin
      pr_state_d = PR_GOT_E0;
    end else if (byte_s == SC_F0) begin
      case (pr_state_q)
        PR_NORMAL: pr_state_d = PR_GOT_F0;
        PR_GOT_E0: pr_state_d = PR_GOT_E0F0;
        default:   pr_state_d = pr_state_q;
      endcase
    end else begin
      pr_state_d = PR_NORMAL;
    end
  end

  // Protocol outputs: modifier flags, held key and the key_valid strobe
  always_comb begin
    held_d      = held_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    key_valid_d = 1'b0;
    if (!data_byte_s) begin
      held_d = held_q;
    end else if (!ext_s && (byte_s == SC_LSHIFT)) begin
      lshift_d = !brk_s;
    end else if (!ext_s && (byte_s == SC_RSHIFT)) begin
      rshift_d = !brk_s;
    end else if (!ext_s && (byte_s == SC_CAPS)) begin
      if (!brk_s) caps_d = ~caps_q;
      else        caps_d = caps_q;
`ifndef PS2_EXT_KEYS_EN
    end else if (ext_s) begin
      held_d = held_q;
`endif
    end else if (!brk_s) begin
      held_d      = code_s;
      key_valid_d = (cand_ascii_s != 8'h00);
    end else if (held_q == code_s) begin
      held_d = 9'd0;
    end else begin
      held_d = held_q;
    end
  end

  // Frame result outputs
  always_comb begin
    frame_err_d = ((fr_state_q == FR_CHECK) && !frame_good_s) ||
                  ((fr_state_q == FR_RECV) && tmo_hit_s);
    if (byte_stb_s) scan_code_d = byte_s;
    else            scan_code_d = scan_code_q;
    shift_on_d = lshift_d | rshift_d;
    ascii_d    = held_ascii_s;
  end

  // Key state and registered outputs
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      held_q      <= 9'd0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      shift_on_q  <= 1'b0;
      caps_q      <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      scan_code_q <= 8'h00;
      ascii_q     <= 8'h00;
    end else begin
      held_q      <= held_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      shift_on_q  <= shift_on_d;
      caps_q      <= caps_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
      scan_code_q <= scan_code_d;
      ascii_q     <= ascii_d;
    end
  end

  assign ascii_key = ascii_q;
  assign scan_code = scan_code_q;
  assign key_valid = key_valid_q;
  assign shift_on  = shift_on_q;
  assign caps_on   = caps_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a scoreboard for key_valid and frame_err pulses.
module tb_ps2_key_decoder;

  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic       clk      = 1'b0;
  logic       clrn     = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ascii_key, scan_code;
  logic       key_valid, shift_on, caps_on, frame_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] kv_q[$];
  logic [7:0] err_q[$];
  logic       kv_prev = 1'b0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ascii_key(ascii_key), .scan_code(scan_code), .key_valid(key_valid),
    .shift_on(shift_on), .caps_on(caps_on), .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_v);
    logic [10:0] bits;
    bits = {stop_v, (~^b) ^ par_flip, b, 1'b0};
    send_bits(bits, 11);
    repeat (30) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  // Scoreboard: pop an expected entry on each output pulse
  always @(negedge clk) begin
    if (clrn) begin
      if (key_valid) begin
        check("kv_width", {7'd0, kv_prev}, 8'h00);
        if (kv_q.size() == 0) check("kv_unexpected", {7'd0, key_valid}, 8'h00);
        else                  check("kv_scan", scan_code, kv_q.pop_front());
      end
      if (frame_err) begin
        if (err_q.size() == 0) check("err_unexpected", {7'd0, frame_err}, 8'h00);
        else                   check("err_scan", scan_code, err_q.pop_front());
      end
      kv_prev = key_valid;
    end else begin
      kv_prev = 1'b0;
    end
  end

  initial begin
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ascii", ascii_key, 8'h00);
    check("rst_scan", scan_code, 8'h00);
    check("rst_flags", {4'd0, key_valid, shift_on, caps_on, frame_err}, 8'h00);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    // plain 'a' press and release
    kv_q.push_back(8'h1C); key(8'h1C);
    check("a_ascii", ascii_key, 8'h61);
    check("a_scan", scan_code, 8'h1C);
    key(8'hF0); key(8'h1C);
    check("a_break", ascii_key, 8'h00);

    // Shift + a
    key(8'h12);
    check("shift_on", {7'd0, shift_on}, 8'h01);
    kv_q.push_back(8'h1C); key(8'h1C);
    check("A_ascii", ascii_key, 8'h41);
    key(8'hF0); key(8'h1C);
    check("A_break", ascii_key, 8'h00);
    key(8'hF0); key(8'h12);
    check("shift_off", {7'd0, shift_on}, 8'h00);

    // Caps Lock, then Shift cancelling it live
    key(8'h58); key(8'hF0); key(8'h58);
    check("caps_on", {7'd0, caps_on}, 8'h01);
    kv_q.push_back(8'h1C); key(8'h1C);
    check("caps_A", ascii_key, 8'h41);
    key(8'h59);
    check("caps_shift_a", ascii_key, 8'h61);
    key(8'hF0); key(8'h59);
    check("caps_unshift", ascii_key, 8'h41);
    key(8'hF0); key(8'h1C);
    key(8'h58); key(8'hF0); key(8'h58);
    check("caps_off", {7'd0, caps_on}, 8'h00);

    // bad parity, bad stop
    err_q.push_back(8'h58); send_frame(8'h1C, 1'b1, 1'b1);
    err_q.push_back(8'h58); send_frame(8'h1C, 1'b0, 1'b0);
    check("bad_ascii", ascii_key, 8'h00);
    check("bad_scan", scan_code, 8'h58);

    // partial frame then timeout; next frame still decodes
    err_q.push_back(8'h58);
    send_bits(11'b000_0011_1000, 5);
    repeat (TMO + 60) @(negedge clk);
    check("tmo_err_seen", 8'(err_q.size()), 8'h00);
    kv_q.push_back(8'h29); key(8'h29);
    check("space", ascii_key, 8'h20);
    key(8'hF0); key(8'h29);

    // extended key while 'a' is held
    kv_q.push_back(8'h1C); key(8'h1C);
`ifdef PS2_EXT_KEYS_EN
    kv_q.push_back(8'h75); key(8'hE0); key(8'h75);
    check("ext_up", ascii_key, 8'h80);
    key(8'hE0); key(8'hF0); key(8'h75);
    check("ext_up_break", ascii_key, 8'h00);
`else
    key(8'hE0); key(8'h75);
    check("ext_ignored", ascii_key, 8'h61);
    key(8'hE0); key(8'hF0); key(8'h75);
    check("ext_brk_ignored", ascii_key, 8'h61);
`endif
    key(8'hF0); key(8'h1C);
    check("ext_after", ascii_key, 8'h00);

    // reset in the middle of a frame
    key(8'h58); key(8'h12);
    kv_q.push_back(8'h1C); key(8'h1C);
    check("pre_rst_ascii", ascii_key, 8'h61);
    send_bits(11'b111_1111_0100, 4);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_ascii", ascii_key, 8'h00);
    check("mid_rst_scan", scan_code, 8'h00);
    check("mid_rst_flags", {4'd0, key_valid, shift_on, caps_on, frame_err}, 8'h00);
    clrn = 1'b1;
    repeat (10) @(negedge clk);
    kv_q.push_back(8'h29); key(8'h29);
    check("post_rst_space", ascii_key, 8'h20);
    check("post_rst_caps", {7'd0, caps_on}, 8'h00);

    repeat (10) @(negedge clk);
    check("kv_pending", 8'(kv_q.size()), 8'h00);
    check("err_pending", 8'(err_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
